// File: rtl/alu_taylor_ctrl.sv
// Taylor-series sequencer: sums coef[i]*x^i/i! through one shared saturating 18x18 Q1.16 multiplier.
// Latency 3*last+2 cycles from start to done; no backpressure, and start is ignored unless idle.
module alu_taylor_ctrl #(
    parameter int MAX_IDX = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  function_sel,
    input  logic [17:0] x,
    output logic [2:0]  taylor_function_sel,
    output logic [3:0]  taylor_idx,
    input  logic [17:0] taylor_deriv_coef,
    output logic        busy,
    output logic        done,
    output logic [17:0] result
);

    localparam logic [2:0]  ALU_TAYLOR_SIN          = 3'd0;
    localparam logic [2:0]  ALU_TAYLOR_COS          = 3'd1;
    localparam logic [2:0]  ALU_TAYLOR_INV_1_PLUS_X = 3'd2;

    localparam logic [17:0] Q_ONE = 18'h10000;
    localparam logic [17:0] Q_MAX = 18'h1FFFF;
    localparam logic [17:0] Q_MIN = 18'h20000;
    localparam logic [3:0]  MAX_IDX_L = 4'(MAX_IDX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAC,
        S_MULX,
        S_MULINV,
        S_DONE
    } state_t;

    state_t      state_q,  state_d;
    logic [2:0]  fsel_q,   fsel_d;
    logic [17:0] x_q,      x_d;
    logic [3:0]  idx_q,    idx_d;
    logic [17:0] p_q,      p_d;
    logic [17:0] t_q,      t_d;
    logic [17:0] acc_q,    acc_d;
    logic [17:0] result_q, result_d;

    logic [3:0]         fn_last;
    logic [3:0]         last_idx;
    logic [3:0]         idx_inc;
    logic [17:0]        inv_val;
    logic               sel_ok;
    logic signed [17:0] mul_a;
    logic signed [17:0] mul_b;
    logic signed [35:0] mul_prod;
    logic [17:0]        mul_res;
    logic signed [18:0] acc_sum;
    logic [17:0]        acc_sat;
    logic               unused_frac;

    always_comb begin
        fn_last = 4'd0;
        case (fsel_q)
            ALU_TAYLOR_SIN:          fn_last = 4'd10;
            ALU_TAYLOR_COS:          fn_last = 4'd9;
            ALU_TAYLOR_INV_1_PLUS_X: fn_last = 4'd9;
            default:                 fn_last = 4'd0;
        endcase
        last_idx = (fn_last > MAX_IDX_L) ? MAX_IDX_L : fn_last;
    end

    assign sel_ok  = (function_sel == ALU_TAYLOR_SIN) ||
                     (function_sel == ALU_TAYLOR_COS) ||
                     (function_sel == ALU_TAYLOR_INV_1_PLUS_X);
    assign idx_inc = idx_q + 4'd1;

    // Q1.16 reciprocals 1/n, applied when stepping from term idx to idx+1.
    always_comb begin
        inv_val = 18'h00000;
        case (idx_inc)
            4'd1:    inv_val = 18'h10000;
            4'd2:    inv_val = 18'h08000;
            4'd3:    inv_val = 18'h05555;
            4'd4:    inv_val = 18'h04000;
            4'd5:    inv_val = 18'h03333;
            4'd6:    inv_val = 18'h02AAA;
            4'd7:    inv_val = 18'h02492;
            4'd8:    inv_val = 18'h02000;
            4'd9:    inv_val = 18'h01C71;
            4'd10:   inv_val = 18'h01999;
            default: inv_val = 18'h00000;
        endcase
    end

    // The single multiplier is owned by whichever arithmetic state is active.
    always_comb begin
        mul_a = 18'sd0;
        mul_b = 18'sd0;
        case (state_q)
            S_MAC: begin
                mul_a = taylor_deriv_coef;
                mul_b = p_q;
            end
            S_MULX: begin
                mul_a = p_q;
                mul_b = x_q;
            end
            S_MULINV: begin
                mul_a = t_q;
                mul_b = inv_val;
            end
            default: begin
                mul_a = 18'sd0;
                mul_b = 18'sd0;
            end
        endcase
    end

    assign mul_prod    = mul_a * mul_b;
    assign unused_frac = ^mul_prod[15:0];

    // Product >> 16 fits in 18 bits only when the three top bits agree.
    always_comb begin
        if ((mul_prod[35:33] == 3'b000) || (mul_prod[35:33] == 3'b111)) begin
            mul_res = mul_prod[33:16];
        end else begin
            mul_res = mul_prod[35] ? Q_MIN : Q_MAX;
        end
    end

    assign acc_sum = $signed({acc_q[17], acc_q}) + $signed({mul_res[17], mul_res});

    always_comb begin
        if (acc_sum[18] != acc_sum[17]) begin
            acc_sat = acc_sum[18] ? Q_MIN : Q_MAX;
        end else begin
            acc_sat = acc_sum[17:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        fsel_d   = fsel_q;
        x_d      = x_q;
        idx_d    = idx_q;
        p_d      = p_q;
        t_d      = t_q;
        acc_d    = acc_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    fsel_d = function_sel;
                    x_d    = x;
                    idx_d  = 4'd0;
                    p_d    = Q_ONE;
                    acc_d  = 18'h00000;
                    if (sel_ok) begin
                        state_d = S_MAC;
                    end else begin
                        result_d = 18'h00000;
                        state_d  = S_DONE;
                    end
                end
            end
            S_MAC: begin
                acc_d = acc_sat;
                if (idx_q == last_idx) begin
                    // Load result on the way into DONE so it is valid alongside the done pulse.
                    result_d = acc_sat;
                    state_d  = S_DONE;
                end else begin
                    state_d = S_MULX;
                end
            end
            S_MULX: begin
                t_d     = mul_res;
                state_d = S_MULINV;
            end
            S_MULINV: begin
                p_d     = mul_res;
                idx_d   = idx_inc;
                state_d = S_MAC;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            fsel_q   <= 3'd0;
            x_q      <= 18'h00000;
            idx_q    <= 4'd0;
            p_q      <= 18'h00000;
            t_q      <= 18'h00000;
            acc_q    <= 18'h00000;
            result_q <= 18'h00000;
        end else begin
            state_q  <= state_d;
            fsel_q   <= fsel_d;
            x_q      <= x_d;
            idx_q    <= idx_d;
            p_q      <= p_d;
            t_q      <= t_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign taylor_function_sel = fsel_q;
    assign taylor_idx          = idx_q;
    assign busy                = (state_q != S_IDLE);
    assign done                = (state_q == S_DONE);
    assign result              = result_q;

endmodule
